// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
   localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned, so the low two address bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~64'h3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction queue holding {pc, instr} entries between imem and decode.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_entry,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; flush empties the queue without touching storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one fetch per cycle, redirect flush.
// Optional misaligned-redirect halting is enabled with FETCH_MISALIGN_CHECK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_misaligned
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] inflight_pc;
   logic            inflight;
   logic            kill;
   logic            halted;
   logic            accepted;
   logic            push;
   logic            pop;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   // An outstanding request already owns a queue slot, so it counts toward occupancy.
   assign occupancy      = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign imem_req_valid = !reset && !halted && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = fpc;
   assign accepted       = imem_req_valid && imem_req_ready;

   assign inst_valid = (count != '0);
   assign inst_data  = head.instr;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready && !redirect_valid;
   assign push       = imem_rsp_valid && !kill && !redirect_valid;
   assign push_entry = '{pc: inflight_pc, instr: imem_rsp_data};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   // The in-flight PC pairs with the response one cycle later; kill drops a stale one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         kill        <= 1'b0;
      end else begin
         inflight <= accepted;
         if (accepted) begin
            inflight_pc <= fpc;
         end
         if (redirect_valid) begin
            fpc  <= align_pc(redirect_pc);
            kill <= accepted;
         end else begin
            if (accepted) begin
               fpc <= fpc + 64'd4;
            end
            if (imem_rsp_valid) begin
               kill <= 1'b0;
            end
         end
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // A misaligned target stops fetching until an aligned redirect arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halted           <= 1'b0;
         fetch_misaligned <= 1'b0;
      end else if (redirect_valid) begin
         halted           <= (redirect_pc[1:0] != 2'b00);
         fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign halted           = 1'b0;
   assign fetch_misaligned = 1'b0;
`endif

endmodule
